// File: rtl/asym_ram_pkg.sv
// Shared defaults, width ratio and FSM encoding for the asymmetric RAM arbiter.
package asym_ram_pkg;

  localparam int unsigned WIDTHA_DEF     = 16;
  localparam int unsigned WIDTHB_DEF     = 4;
  localparam int unsigned ADDRWIDTHA_DEF = 8;
  localparam int unsigned RATIO          = WIDTHA_DEF / WIDTHB_DEF;
  localparam int unsigned LOG2RATIO      = $clog2(RATIO);
  localparam int unsigned ADDRWIDTHB_DEF = ADDRWIDTHA_DEF + LOG2RATIO;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } arb_state_e;

endpackage

// File: rtl/asym_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the narrow requester, bit 1 the wide one.
module asym_rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic wide_prio_q, wide_prio_d;

  always_comb begin
    gnt         = req;
    wide_prio_d = wide_prio_q;
    if (req == 2'b11) begin
      gnt = wide_prio_q ? 2'b10 : 2'b01;
    end
    // Priority moves to whichever side was not just granted.
    if (advance && (gnt != 2'b00)) begin
      wide_prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wide_prio_q <= 1'b0;
    end else begin
      wide_prio_q <= wide_prio_d;
    end
  end

endmodule

// File: rtl/asym_ram_arb.sv
// Arbitrates a wide and a narrow requester onto one narrow RAM port; wide accesses become
// LSB-first bursts. Define ASYM_ARB_STALL_CNT_EN to add the narrow stall counter output.
module asym_ram_arb
  import asym_ram_pkg::*;
#(
  parameter int unsigned WIDTHA     = WIDTHA_DEF,
  parameter int unsigned WIDTHB     = WIDTHB_DEF,
  parameter int unsigned ADDRWIDTHA = ADDRWIDTHA_DEF,
  parameter int unsigned ADDRWIDTHB = ADDRWIDTHB_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  w_req,
  input  logic                  w_we,
  input  logic [ADDRWIDTHA-1:0] w_addr,
  input  logic [WIDTHA-1:0]     w_wdata,
  output logic                  w_gnt,
  output logic                  w_rvalid,
  output logic [WIDTHA-1:0]     w_rdata,
  input  logic                  n_req,
  input  logic                  n_we,
  input  logic [ADDRWIDTHB-1:0] n_addr,
  input  logic [WIDTHB-1:0]     n_wdata,
  output logic                  n_gnt,
  output logic                  n_rvalid,
  output logic [WIDTHB-1:0]     n_rdata,
  output logic                  ram_we,
  output logic [ADDRWIDTHB-1:0] ram_addr,
  output logic [WIDTHB-1:0]     ram_di,
  input  logic [WIDTHB-1:0]     ram_do
`ifdef ASYM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [LOG2RATIO-1:0] LastBeat = LOG2RATIO'(RATIO - 1);

  arb_state_e            state_q, state_d;
  logic [LOG2RATIO-1:0]  beat_q, beat_d;
  logic [1:0]            arb_req, arb_gnt;
  logic                  capture;
  logic                  we_q;
  logic [ADDRWIDTHA-1:0] addr_q;
  logic [WIDTHA-1:0]     wdata_q;
  // Read-return tracking: what was issued to the RAM in the previous cycle.
  logic                  nrd_q, nrd_d;
  logic                  wrd_q, wrd_d;
  logic [LOG2RATIO-1:0]  wbeat_q, wbeat_d;
  logic [WIDTHA-1:0]     acc_q, w_rdata_q;
  logic [WIDTHB-1:0]     n_rdata_q;

  // Reset gates the requests so no grant or RAM write escapes while rstn is low.
  assign arb_req = (rstn && (state_q == StIdle)) ? {w_req, n_req} : 2'b00;

  asym_rr_arb2 u_rr_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (arb_req),
    .advance (state_q == StIdle),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    capture  = 1'b0;
    n_gnt    = 1'b0;
    w_gnt    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    nrd_d    = 1'b0;
    wrd_d    = 1'b0;
    wbeat_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_gnt[0]) begin
          n_gnt    = 1'b1;
          ram_we   = n_we;
          ram_addr = n_addr;
          ram_di   = n_wdata;
          nrd_d    = !n_we;
        end else if (arb_gnt[1]) begin
          w_gnt    = 1'b1;
          capture  = 1'b1;
          ram_we   = w_we;
          ram_addr = {w_addr, {LOG2RATIO{1'b0}}};
          ram_di   = w_wdata[WIDTHB-1:0];
          wrd_d    = !w_we;
          state_d  = StBurst;
          beat_d   = LOG2RATIO'(1);
        end
      end
      StBurst: begin
        ram_we   = we_q;
        ram_addr = {addr_q, beat_q};
        ram_di   = wdata_q[beat_q*WIDTHB +: WIDTHB];
        wrd_d    = !we_q;
        wbeat_d  = beat_q;
        beat_d   = beat_q + LOG2RATIO'(1);
        if (beat_q == LastBeat) begin
          state_d = StIdle;
          beat_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      beat_q  <= '0;
      nrd_q   <= 1'b0;
      wrd_q   <= 1'b0;
      wbeat_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      nrd_q   <= nrd_d;
      wrd_q   <= wrd_d;
      wbeat_q <= wbeat_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
      w_rdata_q <= '0;
      n_rdata_q <= '0;
    end else begin
      if (capture) begin
        we_q    <= w_we;
        addr_q  <= w_addr;
        wdata_q <= w_wdata;
      end
      if (wrd_q) begin
        acc_q[wbeat_q*WIDTHB +: WIDTHB] <= ram_do;
      end
      if (w_rvalid) begin
        w_rdata_q <= w_rdata;
      end
      if (nrd_q) begin
        n_rdata_q <= ram_do;
      end
    end
  end

  assign w_rvalid = wrd_q && (wbeat_q == LastBeat);
  assign n_rvalid = nrd_q;
  assign n_rdata  = nrd_q ? ram_do : n_rdata_q;

  // The last nibble is taken straight from the RAM so data lines up with w_rvalid.
  always_comb begin
    w_rdata = w_rdata_q;
    if (w_rvalid) begin
      w_rdata = acc_q;
      w_rdata[(RATIO-1)*WIDTHB +: WIDTHB] = ram_do;
    end
  end

`ifdef ASYM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (n_req && !n_gnt && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_asym_ram_arb.sv
// Directed bench for asym_ram_arb with a behavioural registered-address RAM.
module tb_asym_ram_arb;

  logic        clk;
  logic        rstn;
  logic        w_req, w_we;
  logic [7:0]  w_addr;
  logic [15:0] w_wdata;
  logic        w_gnt, w_rvalid;
  logic [15:0] w_rdata;
  logic        n_req, n_we;
  logic [9:0]  n_addr;
  logic [3:0]  n_wdata;
  logic        n_gnt, n_rvalid;
  logic [3:0]  n_rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_di;
  logic [3:0]  ram_do;
`ifdef ASYM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk;
  int n_fail;
  logic [3:0] mem [1024];

  asym_ram_arb dut (
    .clk      (clk),
    .rstn     (rstn),
    .w_req    (w_req),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_wdata  (w_wdata),
    .w_gnt    (w_gnt),
    .w_rvalid (w_rvalid),
    .w_rdata  (w_rdata),
    .n_req    (n_req),
    .n_we     (n_we),
    .n_addr   (n_addr),
    .n_wdata  (n_wdata),
    .n_gnt    (n_gnt),
    .n_rvalid (n_rvalid),
    .n_rdata  (n_rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
`ifdef ASYM_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [10:0] exp_n;
    logic [10:0] exp_w;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    ram_do  = 4'h0;
    rstn    = 1'b0;
    w_req   = 1'b1;
    w_we    = 1'b1;
    w_addr  = 8'h00;
    w_wdata = 16'h0000;
    n_req   = 1'b1;
    n_we    = 1'b1;
    n_addr  = 10'h000;
    n_wdata = 4'h0;

    // Reset: requests are held high but nothing may be granted or written.
    tick(); tick(); settle();
    chk("rst_w_gnt", 32'(w_gnt), 0);
    chk("rst_n_gnt", 32'(n_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_w_rvalid", 32'(w_rvalid), 0);
    chk("rst_n_rvalid", 32'(n_rvalid), 0);
    chk("rst_w_rdata", 32'(w_rdata), 0);
    chk("rst_n_rdata", 32'(n_rdata), 0);
    tick();
    rstn = 1'b1; w_req = 1'b0; n_req = 1'b0;
    settle();
    chk("idle_ram_we", 32'(ram_we), 0);

    // Narrow write then narrow read of 0x005.
    tick();
    n_req = 1'b1; n_we = 1'b1; n_addr = 10'h005; n_wdata = 4'hA;
    settle();
    chk("nw_gnt", 32'(n_gnt), 1);
    chk("nw_w_gnt", 32'(w_gnt), 0);
    chk("nw_ram_we", 32'(ram_we), 1);
    chk("nw_ram_addr", 32'(ram_addr), 'h005);
    chk("nw_ram_di", 32'(ram_di), 'hA);
    tick();
    n_we = 1'b0; n_wdata = 4'h0;
    settle();
    chk("nr_gnt", 32'(n_gnt), 1);
    chk("nr_ram_we", 32'(ram_we), 0);
    chk("nw_no_rvalid", 32'(n_rvalid), 0);
    tick();
    n_req = 1'b0;
    settle();
    chk("nr_rvalid", 32'(n_rvalid), 1);
    chk("nr_rdata", 32'(n_rdata), 'hA);
    tick(); settle();
    chk("nr_rvalid_pulse", 32'(n_rvalid), 0);

    // Wide write 0x1234 to 0x01: nibbles 4,3,2,1 to 0x004..0x007.
    tick();
    w_req = 1'b1; w_we = 1'b1; w_addr = 8'h01; w_wdata = 16'h1234;
    settle();
    chk("ww_gnt", 32'(w_gnt), 1);
    chk("ww_b0_we", 32'(ram_we), 1);
    chk("ww_b0_addr", 32'(ram_addr), 'h004);
    chk("ww_b0_di", 32'(ram_di), 'h4);
    for (int k = 1; k < 4; k++) begin
      tick();
      w_req = 1'b0; w_addr = 8'h00; w_wdata = 16'h0000;
      settle();
      chk("ww_beat_we", 32'(ram_we), 1);
      chk("ww_beat_addr", 32'(ram_addr), 32'(4 + k));
      chk("ww_beat_di", 32'(ram_di), 32'(4 - k));
      chk("ww_burst_w_gnt", 32'(w_gnt), 0);
    end

    // Wide read of 0x01 granted in the cycle the write burst ends.
    tick();
    w_req = 1'b1; w_we = 1'b0; w_addr = 8'h01;
    settle();
    chk("ww_no_rvalid", 32'(w_rvalid), 0);
    chk("wr_gnt", 32'(w_gnt), 1);
    chk("wr_ram_we", 32'(ram_we), 0);
    chk("wr_b0_addr", 32'(ram_addr), 'h004);
    for (int k = 1; k < 4; k++) begin
      tick();
      w_req = 1'b0;
      settle();
      chk("wr_early_rvalid", 32'(w_rvalid), 0);
    end
    tick(); settle();
    chk("wr_rvalid", 32'(w_rvalid), 1);
    chk("wr_rdata", 32'(w_rdata), 'h1234);
    tick(); settle();
    chk("wr_rvalid_pulse", 32'(w_rvalid), 0);
    chk("wr_rdata_hold", 32'(w_rdata), 'h1234);

    // Wide write 0xFEDC to 0x02 aborted by reset during beat 2.
    tick();
    w_req = 1'b1; w_we = 1'b1; w_addr = 8'h02; w_wdata = 16'hFEDC;
    settle();
    chk("ab_b0_addr", 32'(ram_addr), 'h008);
    chk("ab_b0_di", 32'(ram_di), 'hC);
    tick();
    w_req = 1'b0;
    settle();
    chk("ab_b1_addr", 32'(ram_addr), 'h009);
    chk("ab_b1_we", 32'(ram_we), 1);
    tick();
    rstn = 1'b0;
    settle();
    chk("ab_ram_we", 32'(ram_we), 0);
    chk("ab_ram_addr", 32'(ram_addr), 0);
    chk("ab_w_gnt", 32'(w_gnt), 0);
    chk("ab_w_rvalid", 32'(w_rvalid), 0);
    chk("ab_w_rdata", 32'(w_rdata), 0);
    chk("ab_n_rdata", 32'(n_rdata), 0);
    tick(); settle();
    chk("ab_ram_we2", 32'(ram_we), 0);
    tick();
    rstn = 1'b1;
    settle();
    chk("ab_post_we", 32'(ram_we), 0);
    chk("ab_post_rvalid", 32'(w_rvalid), 0);

    // Back-to-back wide reads of 0x01 and 0x02 with no idle RAM cycle.
    tick();
    w_req = 1'b1; w_we = 1'b0; w_addr = 8'h01;
    settle();
    chk("bb_gnt1", 32'(w_gnt), 1);
    chk("bb_addr0", 32'(ram_addr), 'h004);
    for (int k = 1; k < 4; k++) begin
      tick();
      w_addr = 8'h02;
      settle();
      chk("bb_burst_gnt", 32'(w_gnt), 0);
      chk("bb_addr", 32'(ram_addr), 32'(4 + k));
    end
    tick(); settle();
    chk("bb_rvalid1", 32'(w_rvalid), 1);
    chk("bb_rdata1", 32'(w_rdata), 'h1234);
    chk("bb_gnt2", 32'(w_gnt), 1);
    chk("bb_addr8", 32'(ram_addr), 'h008);
    for (int k = 1; k < 4; k++) begin
      tick();
      w_req = 1'b0;
      settle();
      chk("bb_burst2_addr", 32'(ram_addr), 32'(8 + k));
      chk("bb_rdata_hold", 32'(w_rdata), 'h1234);
    end
    tick(); settle();
    chk("bb_rvalid2", 32'(w_rvalid), 1);
    chk("bb_rdata2_unwritten", 32'(w_rdata), 'h00DC);
    chk("bb_no_gnt", 32'(w_gnt), 0);

    // Both requesters held high from reset: narrow first, then alternating.
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1; w_req = 1'b1; n_req = 1'b1; w_we = 1'b0; n_we = 1'b0;
    w_addr = 8'h03; n_addr = 10'h000;
    exp_n = 11'b10000100001;
    exp_w = 11'b00001000010;
    for (int i = 0; i < 11; i++) begin
      settle();
      chk("rr_n_gnt", 32'(n_gnt), 32'(exp_n[i]));
      chk("rr_w_gnt", 32'(w_gnt), 32'(exp_w[i]));
      tick();
    end
    w_req = 1'b0; n_req = 1'b0;

`ifdef ASYM_ARB_STALL_CNT_EN
    // Narrow request raised after the wide grant stalls for the three burst beats.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    settle();
    chk("sc_reset", 32'(stall_cnt), 0);
    tick();
    w_req = 1'b1; w_we = 1'b0; w_addr = 8'h01;
    settle();
    chk("sc_w_gnt", 32'(w_gnt), 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      w_req = 1'b0; n_req = 1'b1;
      settle();
      chk("sc_n_wait", 32'(n_gnt), 0);
    end
    tick(); settle();
    chk("sc_n_gnt", 32'(n_gnt), 1);
    chk("sc_cnt", 32'(stall_cnt), 3);
    tick();
    n_req = 1'b0;
    settle();
    chk("sc_cnt_hold", 32'(stall_cnt), 3);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
